// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall vector, exception
// flush with redirect PC, stall watchdog and stall-cycle perf counter.
// Ports:
//   clk, rst (sync, active-low)
//   stallreq_if/id/ex/mem : per-stage stall requests
//   excp_valid, excp_is_eret, cp0_epc : exception from memory stage
//   cnt_clear : clears perf_stall_cnt
//   stall[5:0] : hold per stage (bit0 PC .. bit5 WB), combinational
//   flush, new_pc : registered redirect pulse and target
//   stall_timeout : registered watchdog pulse
//   perf_stall_cnt : registered count of cycles with stall[0]=1
module pipe_ctrl #(
  parameter logic [31:0] EXCP_VECTOR = 32'hBFC0_0380,
  parameter int unsigned WDOG_LIMIT  = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic        excp_is_eret,
  input  logic [31:0] cp0_epc,
  input  logic        cnt_clear,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    RUN,
    WAIT_MEM,
    FLUSH
  } state_t;

  localparam logic [15:0] LIM = 16'(WDOG_LIMIT);

  state_t      state, state_d;
  logic [31:0] tgt, tgt_d;
  logic [15:0] run_cnt, run_d;

  always_comb begin
    state_d = state;
    tgt_d   = tgt;
    stall   = 6'b000000;
    unique case (state)
      RUN: begin
        if (excp_valid) begin
          stall   = 6'b011111;
          tgt_d   = excp_is_eret ? cp0_epc : EXCP_VECTOR;
          state_d = stallreq_mem ? WAIT_MEM : FLUSH;
        end else if (stallreq_mem) begin
          stall = 6'b011111;
        end else if (stallreq_ex) begin
          stall = 6'b001111;
        end else if (stallreq_id) begin
          stall = 6'b000111;
        end else if (stallreq_if) begin
          stall = 6'b000011;
        end
      end
      WAIT_MEM: begin
        stall = 6'b011111;
        if (!stallreq_mem) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    // Reset holds nothing, independent of the state register.
    if (!rst) stall = 6'b000000;
  end

  // Watchdog run length; saturates so it never wraps to a false timeout.
  always_comb begin
    run_d = '0;
    if (stall[0]) begin
      run_d = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= RUN;
      tgt            <= '0;
      flush          <= 1'b0;
      new_pc         <= '0;
      stall_timeout  <= 1'b0;
      perf_stall_cnt <= '0;
      run_cnt        <= '0;
    end else begin
      state   <= state_d;
      tgt     <= tgt_d;
      run_cnt <= run_d;
      flush   <= (state_d == FLUSH);
      if (state_d == FLUSH) new_pc <= tgt_d;
      // Fires only on the step onto the limit, so one pulse per run.
      stall_timeout <= (run_d == LIM) && (run_cnt != LIM);
      if (cnt_clear) begin
        perf_stall_cnt <= '0;
      end else if (stall[0] && perf_stall_cnt != 32'hFFFF_FFFF) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: behavioural model compared every
// cycle plus directed literal checks of the key scenarios.
module tb_pipe_ctrl;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_valid, excp_is_eret;
  logic [31:0] cp0_epc;
  logic        cnt_clear;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] perf_stall_cnt;

  pipe_ctrl #(
    .EXCP_VECTOR(32'hBFC0_0380),
    .WDOG_LIMIT (LIMIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excp_valid    (excp_valid),
    .excp_is_eret  (excp_is_eret),
    .cp0_epc       (cp0_epc),
    .cnt_clear     (cnt_clear),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_timeout (stall_timeout),
    .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Model: an exception is either waiting on memory (m_pend) or flushing
  // this cycle (m_flush); otherwise the pipeline runs freely.
  bit          m_flush = 0;
  bit          m_pend  = 0;
  logic [31:0] m_tgt   = 0;
  logic [31:0] m_pc    = 0;
  bit          m_to    = 0;
  longint      m_perf  = 0;
  int          m_run   = 0;

  function automatic logic [5:0] exp_stall();
    if (!rst || m_flush) return 6'b000000;
    if (m_pend || excp_valid || stallreq_mem) return 6'b011111;
    if (stallreq_ex) return 6'b001111;
    if (stallreq_id) return 6'b000111;
    if (stallreq_if) return 6'b000011;
    return 6'b000000;
  endfunction

  always @(posedge clk) begin
    logic [5:0] es;
    bit fire;
    es = exp_stall();
    fire = 0;
    if (!rst) begin
      m_flush = 0; m_pend = 0; m_tgt = 0; m_pc = 0;
      m_to = 0; m_perf = 0; m_run = 0;
    end else begin
      if (m_flush) begin
        fire = 0;
      end else if (m_pend) begin
        fire = !stallreq_mem;
      end else if (excp_valid) begin
        m_tgt = excp_is_eret ? cp0_epc : 32'hBFC0_0380;
        if (stallreq_mem) m_pend = 1;
        else fire = 1;
      end
      m_flush = fire;
      if (fire) begin
        m_pend = 0;
        m_pc = m_tgt;
      end
      if (cnt_clear) m_perf = 0;
      else if (es[0] && m_perf < 64'hFFFF_FFFF) m_perf++;
      m_run = es[0] ? m_run + 1 : 0;
      m_to = es[0] && (m_run == LIMIT);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall", {26'd0, stall}, {26'd0, exp_stall()});
      chk("m_flush", {31'd0, flush}, {31'd0, m_flush});
      chk("m_new_pc", new_pc, m_pc);
      chk("m_timeout", {31'd0, stall_timeout}, {31'd0, m_to});
      chk("m_perf", perf_stall_cnt, m_perf[31:0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int nto;

  initial begin
    rst = 0;
    {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0;
    excp_valid = 0; excp_is_eret = 0; cp0_epc = 0; cnt_clear = 0;
    cyc();
    chk_en = 1;
    cyc();
    @(negedge clk);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_new_pc", new_pc, 32'd0);
    chk("rst_perf", perf_stall_cnt, 32'd0);
    stallreq_mem = 1;
    #1;
    chk("rst_stall_zero", {26'd0, stall}, 32'd0);
    cyc();
    stallreq_mem = 0;
    rst = 1;

    // stall priority
    stallreq_id = 1; stallreq_ex = 1;
    @(negedge clk); chk("stall_id_ex", {26'd0, stall}, 32'h0F);
    cyc();
    stallreq_id = 0; stallreq_ex = 0; stallreq_if = 1;
    @(negedge clk); chk("stall_if", {26'd0, stall}, 32'h03);
    cyc();
    stallreq_if = 0; stallreq_mem = 1;
    @(negedge clk); chk("stall_mem", {26'd0, stall}, 32'h1F);
    cyc();
    stallreq_mem = 0; stallreq_id = 1;
    @(negedge clk); chk("stall_id", {26'd0, stall}, 32'h07);
    cyc();
    stallreq_id = 0;
    @(negedge clk); chk("stall_none", {26'd0, stall}, 32'h00);
    cyc();

    // plain exception, memory idle
    excp_valid = 1; stallreq_ex = 1;
    @(negedge clk); chk("excp_stall", {26'd0, stall}, 32'h1F);
    cyc();
    excp_valid = 0; stallreq_ex = 0;
    @(negedge clk);
    chk("excp_flush", {31'd0, flush}, 32'd1);
    chk("excp_pc", new_pc, 32'hBFC0_0380);
    chk("excp_flush_stall", {26'd0, stall}, 32'h00);
    cyc();
    @(negedge clk);
    chk("excp_flush_end", {31'd0, flush}, 32'd0);
    chk("excp_pc_hold", new_pc, 32'hBFC0_0380);
    cyc();

    // ERET while memory busy
    excp_valid = 1; excp_is_eret = 1; cp0_epc = 32'h8000_1234;
    stallreq_mem = 1;
    @(negedge clk); chk("eret_c0", {26'd0, stall}, 32'h1F);
    cyc();
    excp_valid = 1; excp_is_eret = 0; cp0_epc = 32'h0;
    @(negedge clk); chk("eret_c1", {26'd0, stall}, 32'h1F);
    cyc();
    excp_valid = 0;
    @(negedge clk); chk("eret_c2", {26'd0, stall}, 32'h1F);
    chk("eret_no_flush", {31'd0, flush}, 32'd0);
    cyc();
    stallreq_mem = 0;
    @(negedge clk); chk("eret_c3", {26'd0, stall}, 32'h1F);
    cyc();
    @(negedge clk);
    chk("eret_flush", {31'd0, flush}, 32'd1);
    chk("eret_pc", new_pc, 32'h8000_1234);
    cyc();
    cyc();

    // watchdog and perf counter
    cnt_clear = 1;
    cyc();
    cnt_clear = 0; stallreq_if = 1;
    nto = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (stall_timeout) nto++;
      cyc();
    end
    stallreq_if = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) chk("perf_10", perf_stall_cnt, 32'd10);
      if (stall_timeout) nto++;
      cyc();
    end
    chk("wdog_one_pulse", nto, 32'd1);
    cnt_clear = 1; stallreq_if = 1;
    cyc();
    cnt_clear = 0; stallreq_if = 0;
    @(negedge clk); chk("perf_clear", perf_stall_cnt, 32'd0);
    cyc();

    // reset while waiting on memory
    excp_valid = 1; stallreq_mem = 1;
    cyc();
    excp_valid = 0;
    @(negedge clk); chk("wait_stall", {26'd0, stall}, 32'h1F);
    cyc();
    rst = 0;
    #1;
    chk("rst_wait_stall", {26'd0, stall}, 32'h00);
    cyc();
    rst = 1; stallreq_mem = 0;
    nto = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (flush) nto++;
      cyc();
    end
    chk("rst_abort_flush", nto, 32'd0);
    @(negedge clk);
    chk("rst_abort_pc", new_pc, 32'd0);
    chk("rst_abort_perf", perf_stall_cnt, 32'd0);
    cyc();
    chk_en = 0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
